// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared op_x encodings and multiply/divide sequencer state type
//
// Contents:
//   op_mul, op_div   op_x subfunction codes (op_x_bits) that start the sequencer
//   muldiv_state_t   sequencer FSM state (IDLE, RUN, DONE)
package lc3b_types;

    localparam logic [2:0] op_mul = 3'b000;
    localparam logic [2:0] op_div = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift registers, add/subtract unit and iteration counter
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load               capture a/b/div_mode and preset the counter to WIDTH
//   step               perform one multiply or divide iteration
//   div_mode           1 = restoring divide, 0 = shift-add multiply (sampled on load)
//   a, b               multiplicand/dividend, multiplier/divisor (unsigned magnitudes)
//   lo_step, hi_step   register contents after the current iteration
//   last               the iteration being performed this cycle is the final one
module muldiv_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo_step,
    output logic [WIDTH-1:0] hi_step,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One extra bit on the adder: carry out of the multiply add, borrow of the divide trial.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_q) begin
            // Remainder stays below the divisor, so a clear top bit means the trial fits.
            if (!div_diff[WIDTH]) begin
                hi_step = div_diff[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_shift[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift the sum (with carry) right into the product's high half.
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = '0;
            lo_d  = a;
            b_d   = b;
            div_d = div_mode;
            cnt_d = CW'(WIDTH);
        end else if (step) begin
            acc_d = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign last = (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle op_x multiply/divide sequencer for the EXE stage
//
// Build option: MULDIV_SIGNED_EN selects two's-complement operands (unsigned otherwise).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          request (load_alg_reg) and op_x subfunction
//   opA, opB           multiplicand/dividend, multiplier/divisor
//   flush              abort any operation in progress
//   stall              hold IF/ID/EXE while the operation is pending
//   done               one-cycle pulse, results valid
//   res_lo, res_hi     product low/high or quotient/remainder, held until next DONE
//   div_by_zero        last completed divide had a zero divisor
module muldiv_sequencer
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_by_zero
);

    muldiv_state_t    state_q, state_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic             is_div, request;
    logic             dp_load, dp_step, dp_last;
    logic [WIDTH-1:0] dp_a, dp_b, dp_lo, dp_hi;
    logic [WIDTH-1:0] fin_lo, fin_hi;

    assign is_div  = (op == op_div);
    assign request = start && ((op == op_mul) || is_div) && !flush;

`ifdef MULDIV_SIGNED_EN
    // Sign corrections decided at capture and applied as results are loaded.
    logic                 mul_neg_q, mul_neg_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   prod_raw, prod_fix;

    assign dp_a = opA[WIDTH-1] ? -opA : opA;
    assign dp_b = opB[WIDTH-1] ? -opB : opB;

    always_comb begin
        prod_raw = {dp_hi, dp_lo};
        prod_fix = mul_neg_q ? -prod_raw : prod_raw;
        fin_lo   = q_neg_q ? -prod_fix[WIDTH-1:0] : prod_fix[WIDTH-1:0];
        fin_hi   = r_neg_q ? -prod_fix[2*WIDTH-1:WIDTH] : prod_fix[2*WIDTH-1:WIDTH];
    end
`else
    assign dp_a   = opA;
    assign dp_b   = opB;
    assign fin_lo = dp_lo;
    assign fin_hi = dp_hi;
`endif

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dp_load),
        .step     (dp_step),
        .div_mode (is_div),
        .a        (dp_a),
        .b        (dp_b),
        .lo_step  (dp_lo),
        .hi_step  (dp_hi),
        .last     (dp_last)
    );

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        done     = 1'b0;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
        mul_neg_d = mul_neg_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    stall   = 1'b1;
                    dp_load = 1'b1;
                    dbz_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
                    mul_neg_d = !is_div && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    q_neg_d   = is_div && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    r_neg_d   = is_div && opA[WIDTH-1];
`endif
                    if (is_div && (opB == '0)) begin
                        // Zero divisor: results are fixed, no iterations needed.
                        state_d  = DONE;
                        res_lo_d = '1;
                        res_hi_d = opA;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    dp_step = 1'b1;
                    if (dp_last) begin
                        state_d  = DONE;
                        res_lo_d = fin_lo;
                        res_hi_d = fin_hi;
                    end
                end
            end
            DONE: begin
                // Results are already committed, so a flush here cannot cancel the pulse.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            mul_neg_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            mul_neg_q <= mul_neg_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
`endif
        end
    end

    assign res_lo      = res_lo_q;
    assign res_hi      = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed vector bench for muldiv_sequencer (MULDIV_SIGNED_EN aware)
module tb_muldiv_sequencer;
    import lc3b_types::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opA, opB;
    logic         flush;
    logic         stall, done;
    logic [W-1:0] res_lo, res_hi;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .opA         (opA),
        .opB         (opB),
        .flush       (flush),
        .stall       (stall),
        .done        (done),
        .res_lo      (res_lo),
        .res_hi      (res_hi),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] lo, logic [W-1:0] hi, logic dbz);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dbz = dbz;
        v.lat = dbz ? 1 : W + 1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues a one-cycle request and waits (bounded) for done; reports latency and stall cycles.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nstall);
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        #1;
        nstall = (stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (stall === 1'b1) nstall++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nst, d0;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; opA = '0; opB = '0;

`ifdef MULDIV_SIGNED_EN
        vecs.push_back(mk(op_mul, 16'hFFFA, 16'h0007, 16'hFFD6, 16'hFFFF, 1'b0));
        vecs.push_back(mk(op_div, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0));
        vecs.push_back(mk(op_div, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0));
        vecs.push_back(mk(op_div, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0));
        vecs.push_back(mk(op_mul, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(op_mul, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0));
        vecs.push_back(mk(op_div, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b1));
        vecs.push_back(mk(op_div, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0));
`else
        vecs.push_back(mk(op_mul, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0));
        vecs.push_back(mk(op_mul, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0));
        vecs.push_back(mk(op_mul, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0));
        vecs.push_back(mk(op_mul, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(op_div, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0));
        vecs.push_back(mk(op_div, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1'b1));
        vecs.push_back(mk(op_div, 16'h8000, 16'h00FF, 16'h0080, 16'h0080, 1'b0));
        vecs.push_back(mk(op_div, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0));
        vecs.push_back(mk(op_div, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_lo", res_lo, 0);
        check("rst_hi", res_hi, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        // Unsupported op is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd5; opA = 16'h0003; opB = 16'h0004;
        #1 check("badop_stall_req", stall, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("badop_stall_after", stall, 0);

        // Table-driven vectors
        foreach (vecs[k]) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, lat, nst);
            check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            check($sformatf("v%0d_stalls", k), nst, vecs[k].lat);
            check($sformatf("v%0d_lo", k), res_lo, vecs[k].lo);
            check($sformatf("v%0d_hi", k), res_hi, vecs[k].hi);
            check($sformatf("v%0d_dbz", k), div_by_zero, vecs[k].dbz);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", k), done, 0);
        end

        // Start held through DONE must not re-trigger
        @(negedge clk);
        op = op_div; opA = 16'd100; opB = 16'd7; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("hold_latency", lat, W + 1);
        check("hold_stall_in_done", stall, 0);
        @(posedge clk);
        #1 start = 1'b0;
        d0 = done_cnt;
        nst = 0;
        repeat (20) begin
            @(negedge clk);
            if (stall === 1'b1) nst++;
        end
        check("hold_no_retrigger_done", done_cnt - d0, 0);
        check("hold_no_retrigger_stall", nst, 0);
        check("hold_lo", res_lo, 16'h000E);
        check("hold_hi", res_hi, 16'h0002);

        // Flush together with start in IDLE
        @(negedge clk);
        op = op_mul; opA = 16'h0002; opB = 16'h0003; start = 1'b1; flush = 1'b1;
        #1 check("flushreq_stall", stall, 0);
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flushreq_stall_after", stall, 0);

        // Flush during iteration 5
        d0 = done_cnt;
        @(negedge clk);
        op = op_mul; opA = 16'hFFFF; opB = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("flush_stall_running", stall, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_stall_drop", stall, 0);
        check("flush_keep_lo", res_lo, 16'h000E);
        check("flush_keep_hi", res_hi, 16'h0002);
        repeat (20) @(negedge clk);
        check("flush_no_done", done_cnt - d0, 0);

        // Flush in DONE still pulses done
        @(negedge clk);
        op = op_mul; opA = 16'h0003; opB = 16'h0005; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (W) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_done_pulse", done, 1);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_done_lo", res_lo, 16'h000F);
        check("flush_done_hi", res_hi, 16'h0000);

        // Asynchronous reset mid-operation
        d0 = done_cnt;
        @(negedge clk);
        op = op_mul; opA = 16'h1234; opB = 16'h0010; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_done", done, 0);
        check("arst_lo", res_lo, 0);
        check("arst_hi", res_hi, 0);
        check("arst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle_stall", stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the op_x multiply/divide group in the EXE stage.
- Accepts a start pulse (the decode packet's load_alg_reg, with op_x_bits) and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Stalls the pipeline while busy and holds lo/hi results for later hi_mul/rem reads (alu_res_sel 4'b1010).
- Result-select muxing stays outside the block.

Parameters:
- WIDTH, 16, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request from EXE (load_alg_reg).
- op  input  3  op_x subfunction (op_x_bits): op_mul or op_div.
- opA  input  WIDTH  multiplicand / dividend.
- opB  input  WIDTH  multiplier / divisor.
- flush  input  1  pipeline flush; aborts any operation.
- stall  output  1  holds IF/ID/EXE while the operation is pending.
- done  output  1  one-cycle pulse; results valid.
- res_lo  output  WIDTH  product[WIDTH-1:0] or quotient.
- res_hi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder.
- div_by_zero  output  1  last completed divide had opB==0; held with the results.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; stall=0, done=0, res_lo=0, res_hi=0, div_by_zero=0; counter and working registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - A request is start=1 && (op==op_mul || op==op_div) && !flush.
  - stall is combinationally 1 in the request cycle. Operands are captured at that edge, counter=WIDTH, and the FSM goes to RUN.
  - start with any other op is ignored; stall stays 0.
- RUN:
  - stall=1. One iteration per cycle; counter decrements.
  - When counter reaches 1, the next edge goes to DONE and loads res_lo/res_hi.
- DONE:
  - done=1, stall=0, then unconditionally back to IDLE.
  - start during DONE is ignored. The stalled instruction advances in this cycle, so no re-trigger occurs.
- Latency: request at edge N; done high in the cycle after edge N+WIDTH (WIDTH+1 stall cycles including the request cycle).
- Multiply: unsigned WIDTH x WIDTH -> 2*WIDTH; lo/hi as above.
- Divide, restoring: quotient in res_lo, remainder in res_hi; invariant opA = q*opB + r, with r < opB.
- Divide by zero (detected at capture): skip RUN and go straight to DONE next edge. res_lo=all-ones, res_hi=opA, div_by_zero=1.
- div_by_zero is cleared on the next accepted request.
- Results and div_by_zero hold their values until the next DONE.
- flush:
  - In RUN: go to IDLE next edge; no done; results unchanged.
  - flush with start in IDLE: request ignored.
  - flush in DONE: done still pulses (result already committed to registers).
- Asynchronous reset mid-operation returns to the reset values immediately; no done pulse.

Optional Feature:
- MULDIV_SIGNED_EN defined:
  - Operands are treated as two's complement. Magnitudes are captured at start, and the sign is applied to results on the DONE transition.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^(WIDTH-1) / -1 gives quotient 0x8000 and remainder 0.
  - Divide by zero behaves exactly as in the unsigned case.
- Not defined: all operations are unsigned; no sign logic is synthesized.

Decomposition:
- lc3b_types supplies op_mul and op_div and gains muldiv_state_t (IDLE/RUN/DONE).
- One natural sub-module: muldiv_datapath, holding the shift registers, the add/subtract unit and the counter, driven by the FSM in muldiv_sequencer.

Test Plan:
- mul 0x1234 * 0x0010:
  - stall high for 17 cycles; done in cycle 17 after the request edge.
  - res_hi=0x0001, res_lo=0x2340.
- mul 0xFFFF * 0xFFFF: res_hi=0xFFFE, res_lo=0x0001, div_by_zero=0.
- div 100 / 7: res_lo=0x000E, res_hi=0x0002; a repeated start held during DONE triggers no second operation.
- div 0x00AB / 0: done one cycle after the request edge; res_lo=0xFFFF, res_hi=0x00AB, div_by_zero=1; the next valid divide clears it.
- flush at iteration 5, then rst_n low during a second operation:
  - No done from either operation.
  - After the flush, prior results are retained and stall drops the next cycle.
  - After reset, all outputs are 0.
- MULDIV_SIGNED_EN:
  - -6 * 7 gives hi=0xFFFF, lo=0xFFD6.
  - -7 / 2 gives q=0xFFFD, r=0xFFFF.
  - 0x8000 / 0xFFFF gives q=0x8000, r=0.
